// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler: state encoding,
// byte-1 bit positions and the default inter-byte timeout.
package ps2_pkg;

  typedef enum logic [1:0] {
    WAIT_B1 = 2'd0,
    WAIT_B2 = 2'd1,
    WAIT_B3 = 2'd2
  } ps2_state_e;

  // Byte 1 layout: {Yv, Xv, Y8, X8, 1, M, R, L}
  localparam int PS2_B1_L    = 0;
  localparam int PS2_B1_R    = 1;
  localparam int PS2_B1_M    = 2;
  localparam int PS2_B1_SYNC = 3;
  localparam int PS2_B1_XS   = 4;
  localparam int PS2_B1_YS   = 5;
  localparam int PS2_B1_XV   = 6;
  localparam int PS2_B1_YV   = 7;

  localparam int PS2_TIMEOUT_DEFAULT = 100000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap counter: counts while run is high, expired flags the
// TIMEOUT_CYCLES-1 count. clear has priority and returns the count to zero.
module ps2_gap_timer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                    cnt_d = '0;
    else if (run && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles three PS/2 mouse bytes into one packet and counts sync losses.
// Optional inter-byte timeout is built when PS2_PKT_TIMEOUT_EN is defined.
module ps2_mouse_packet
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_en,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ps2_byte_valid,
  output logic [7:0] ps2_byte_1,
  output logic [7:0] ps2_byte_2,
  output logic [7:0] ps2_byte_3,
  output logic [7:0] sync_err_cnt
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_mouse_packet: TIMEOUT_CYCLES must be at least 2");
  end

  ps2_state_e state_q, state_d;
  logic       acc, expired;
  logic       cap_b1, cap_b2, done, err_inc;
  logic [7:0] sh1_q, sh2_q;
  logic [7:0] b1_q, b2_q, b3_q, err_q;
  logic       vld_q;

  assign acc = pkt_en && rx_valid;

`ifdef PS2_PKT_TIMEOUT_EN
  logic run, tmr_clear;
  assign run       = pkt_en && (state_q != WAIT_B1);
  // Restart on every accepted byte and after an abort so WAIT_B1 sees zero.
  assign tmr_clear = !run || rx_valid || expired;

  ps2_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .run     (run),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_B1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!pkt_en) begin
      state_d = WAIT_B1;
    end else begin
      unique case (state_q)
        WAIT_B1: if (acc && rx_data[PS2_B1_SYNC]) state_d = WAIT_B2;
        WAIT_B2: if (acc) state_d = WAIT_B3;
                 else if (expired) state_d = WAIT_B1;
        WAIT_B3: if (acc || expired) state_d = WAIT_B1;
        default: state_d = WAIT_B1;
      endcase
    end
  end

  // A byte arriving on the expiry cycle wins over the abort.
  always_comb begin
    cap_b1  = acc && (state_q == WAIT_B1) &&  rx_data[PS2_B1_SYNC];
    cap_b2  = acc && (state_q == WAIT_B2);
    done    = acc && (state_q == WAIT_B3);
    err_inc = (acc && (state_q == WAIT_B1) && !rx_data[PS2_B1_SYNC]) ||
              (pkt_en && !rx_valid && expired && (state_q != WAIT_B1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh1_q <= '0;
      sh2_q <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
      b3_q  <= '0;
      vld_q <= 1'b0;
      err_q <= '0;
    end else begin
      vld_q <= done;
      if (cap_b1) sh1_q <= rx_data;
      if (cap_b2) sh2_q <= rx_data;
      if (done) begin
        b1_q <= sh1_q;
        b2_q <= sh2_q;
        b3_q <= rx_data;
      end
      if (err_inc) err_q <= sat_inc8(err_q);
    end
  end

  assign ps2_byte_valid = vld_q;
  assign ps2_byte_1     = b1_q;
  assign ps2_byte_2     = b2_q;
  assign ps2_byte_3     = b3_q;
  assign sync_err_cnt   = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Randomized and directed bench for ps2_mouse_packet, checked every cycle
// against a queue-based packet model; timeout cases run under PS2_PKT_TIMEOUT_EN.
module tb_ps2_mouse_packet;

  localparam int T = 16;
`ifdef PS2_PKT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_en = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ps2_byte_valid;
  logic [7:0] ps2_byte_1, ps2_byte_2, ps2_byte_3, sync_err_cnt;

  ps2_mouse_packet #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_en         (pkt_en),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .ps2_byte_valid (ps2_byte_valid),
    .ps2_byte_1     (ps2_byte_1),
    .ps2_byte_2     (ps2_byte_2),
    .ps2_byte_3     (ps2_byte_3),
    .sync_err_cnt   (sync_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Behavioural model: pending bytes in a queue, gap measured in cycles.
  logic [7:0] part[$];
  logic       m_v = 1'b0;
  logic [7:0] m_b1 = 8'h00, m_b2 = 8'h00, m_b3 = 8'h00, m_err = 8'h00;
  int         cyc = 0;
  int         last_acc = 0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    m_v = 1'b0;
    if (rst) begin
      part.delete();
      m_b1 = 8'h00; m_b2 = 8'h00; m_b3 = 8'h00; m_err = 8'h00;
    end else if (!pkt_en) begin
      part.delete();
    end else if (rx_valid) begin
      if (part.size() == 0 && !rx_data[3]) begin
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end else begin
        part.push_back(rx_data);
      end
      if (part.size() == 3) begin
        m_b1 = part[0]; m_b2 = part[1]; m_b3 = part[2];
        m_v = 1'b1;
        part.delete();
      end
      last_acc = cyc;
    end else if (TO_EN && part.size() != 0 && (cyc - last_acc) >= T) begin
      part.delete();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if ({ps2_byte_valid, ps2_byte_1, ps2_byte_2, ps2_byte_3, sync_err_cnt} !==
          {m_v, m_b1, m_b2, m_b3, m_err}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model cyc=%0d got v=%b %h/%h/%h err=%0d want v=%b %h/%h/%h err=%0d",
                   cyc, ps2_byte_valid, ps2_byte_1, ps2_byte_2, ps2_byte_3, sync_err_cnt,
                   m_v, m_b1, m_b2, m_b3, m_err);
      end
      if (ps2_byte_valid) pulses++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_pkt(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    check({name, "_b1"}, ps2_byte_1, a);
    check({name, "_b2"}, ps2_byte_2, b);
    check({name, "_b3"}, ps2_byte_3, c);
  endtask

  initial begin
    int p0;
    int r;
    logic [7:0] d;

    idle(2);
    rst = 1'b0;
    pkt_en = 1'b1;
    check("rst_valid", ps2_byte_valid, 0);
    check_pkt("rst", 8'h00, 8'h00, 8'h00);
    check("rst_err", sync_err_cnt, 0);

    // Spaced packet, pulse exactly one cycle after byte 3
    send(8'h09); idle(9); send(8'h05); idle(9);
    check("sp_pre_valid", ps2_byte_valid, 0);
    send(8'hFB);
    check("sp_valid", ps2_byte_valid, 1);
    check_pkt("sp", 8'h09, 8'h05, 8'hFB);
    idle(1);
    check("sp_valid_off", ps2_byte_valid, 0);

    // Leading unsynced byte dropped, back-to-back packet follows
    send(8'h00); send(8'h08); send(8'h10); send(8'h20);
    check("drop_err", sync_err_cnt, 1);
    check("drop_valid", ps2_byte_valid, 1);
    check_pkt("drop", 8'h08, 8'h10, 8'h20);

`ifdef PS2_PKT_TIMEOUT_EN
    do_reset();
    idle(1);
    p0 = pulses;
    send(8'h08); send(8'h01); idle(20);
    check("to_abort_err", sync_err_cnt, 1);
    send(8'h09); send(8'h02); send(8'h03);
    idle(1);
    check("to_err", sync_err_cnt, 1);
    check("to_pulses", pulses - p0, 1);
    check_pkt("to", 8'h09, 8'h02, 8'h03);

    // Byte 3 lands on the expiry cycle
    send(8'h08); send(8'h01); idle(T - 1); send(8'h03);
    check("edge_valid", ps2_byte_valid, 1);
    check_pkt("edge", 8'h08, 8'h01, 8'h03);
    check("edge_err", sync_err_cnt, 1);
`endif

    // Reset mid-packet
    send(8'h0C); send(8'h0D);
    p0 = pulses;
    do_reset();
    check_pkt("mid_rst", 8'h00, 8'h00, 8'h00);
    check("mid_rst_err", sync_err_cnt, 0);
    send(8'h0A); send(8'h01); send(8'h02);
    idle(1);
    check("mid_rst_pulses", pulses - p0, 1);
    check_pkt("mid_rst_pkt", 8'h0A, 8'h01, 8'h02);

    // pkt_en low discards a partial packet without counting an error
    send(8'h18); send(8'h22);
    pkt_en = 1'b0;
    send(8'h33);
    pkt_en = 1'b1;
    send(8'h28); send(8'h44); send(8'h55);
    check("en_err", sync_err_cnt, 0);
    check_pkt("en", 8'h28, 8'h44, 8'h55);

    // Saturation
    do_reset();
    idle(1);
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      d[3] = 1'b0;
      send(d);
    end
    idle(1);
    check("sat_err", sync_err_cnt, 255);
    check("sat_pulses", pulses - p0, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 5) begin
        pkt_en = 1'b0;
        rx_valid = $urandom_range(0, 1);
        rx_data = $urandom;
        idle($urandom_range(1, 3));
        rx_valid = 1'b0;
        pkt_en = 1'b1;
      end else if (r < 11) begin
        idle($urandom_range(T - 3, T + 2));
      end else begin
        d = $urandom;
        if ($urandom_range(0, 9) < 8) d[3] = 1'b1;
        send(d);
        idle($urandom_range(0, 2));
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet.md
PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: maximum idle clk cycles allowed between bytes of one packet.
REQ-002 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pkt_en  input  1  assembler enable; low forces WAIT_B1 and suppresses output.
REQ-005 rx_valid  input  1  one-cycle strobe, a byte was received from the PS/2 receiver.
REQ-006 rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-007 ps2_byte_valid  output  1  one-cycle pulse, complete packet presented.
REQ-008 ps2_byte_1  output  8  packet byte 1 {Yv,Xv,Y8,X8,1,M,R,L}, held until the next packet.
REQ-009 ps2_byte_2  output  8  packet byte 2, X movement [7:0], held.
REQ-010 ps2_byte_3  output  8  packet byte 3, Y movement [7:0], held.
REQ-011 sync_err_cnt  output  8  saturating count of dropped bytes and aborted packets.

Function
REQ-012 State machine SHALL have states WAIT_B1, WAIT_B2 and WAIT_B3.
REQ-013 In WAIT_B1, rx_valid with rx_data[3]=1 SHALL capture byte 1 into a shadow register and move to WAIT_B2.
REQ-014 In WAIT_B1, rx_valid with rx_data[3]=0 SHALL drop the byte, stay in WAIT_B1 and increment sync_err_cnt.
REQ-015 In WAIT_B2, rx_valid SHALL capture byte 2 into a shadow register and move to WAIT_B3.
REQ-016 In WAIT_B3, rx_valid SHALL copy shadow byte 1, shadow byte 2 and rx_data to ps2_byte_1/2/3 and return to WAIT_B1.
REQ-017 That transfer SHALL pulse ps2_byte_valid high for exactly one cycle.
REQ-018 ps2_byte_valid and the new ps2_byte_1/2/3 values SHALL appear on the cycle after the rx_valid of byte 3 (latency 1).
REQ-019 ps2_byte_1/2/3 SHALL change only on a completed packet; partial packets never modify them.
REQ-020 Byte contents SHALL be passed through unmodified, with no sign or overflow processing.
REQ-021 pkt_en=0 SHALL force WAIT_B1 and discard any partial packet without incrementing sync_err_cnt.
REQ-022 pkt_en=0 SHALL hold ps2_byte_valid at 0 and ignore rx_valid.
REQ-023 sync_err_cnt SHALL saturate at 255 and clear only on rst.
REQ-024 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no byte lost.

Reset
REQ-025 rst SHALL set state to WAIT_B1, ps2_byte_valid=0, ps2_byte_1/2/3=8'h00, shadow registers=0, sync_err_cnt=0 and gap counter=0.
REQ-026 rst asserted mid-packet SHALL discard the partial packet, and no ps2_byte_valid pulse SHALL follow.

Configuration
REQ-027 Macro PS2_PKT_TIMEOUT_EN defined: a gap counter SHALL run in WAIT_B2/WAIT_B3, clear on each accepted byte, and hold at 0 in WAIT_B1.
REQ-028 With PS2_PKT_TIMEOUT_EN defined, the gap counter reaching TIMEOUT_CYCLES-1 without rx_valid SHALL abort to WAIT_B1 and increment sync_err_cnt.
REQ-029 With PS2_PKT_TIMEOUT_EN defined, rx_valid in the same cycle as expiry SHALL win: the byte is accepted and there is no abort.
REQ-030 Macro PS2_PKT_TIMEOUT_EN undefined: no gap counter SHALL be built, and WAIT_B2/WAIT_B3 wait indefinitely.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the state encoding, the byte-1 bit index constants (L=0, R=1, M=2, SYNC=3, XS=4, YS=5, XV=6, YV=7) and the default TIMEOUT_CYCLES.
REQ-032 Gap counter SHALL be one sub-module ps2_gap_timer (inputs clear and run; output expired), width $clog2(TIMEOUT_CYCLES).

Verification
REQ-033 rx bytes 8'h09, 8'h05, 8'hFB spaced 10 cycles -> one ps2_byte_valid pulse 1 cycle after 8'hFB; outputs read 09/05/FB.
REQ-034 Bytes 8'h00, 8'h08, 8'h10, 8'h20 -> 8'h00 dropped, sync_err_cnt=1; packet 08/10/20 delivered.
REQ-035 With PS2_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=16: 8'h08, 8'h01, then 20 idle cycles, then 8'h09, 8'h02, 8'h03 -> abort, sync_err_cnt=1, only packet 09/02/03 delivered.
REQ-036 Byte 3 arriving exactly on the expiry cycle -> packet delivered, sync_err_cnt unchanged.
REQ-037 rst pulsed after byte 2, then 8'h0A, 8'h01, 8'h02 -> all outputs 0 after rst; a single packet 0A/01/02 delivered.
REQ-038 300 bytes with bit3=0 -> sync_err_cnt=255, no ps2_byte_valid pulse.
